// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// microwave_pkg : shared state encoding, BCD constants and digit helper
// Rev 1.0
// ============================================================================
package microwave_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_NINE      = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One stage of a BCD borrow chain: returns {borrow_out, digit_out}.
    function automatic logic [BCD_W:0] bcd_dec_digit(
        input logic [BCD_W-1:0] digit,
        input logic             borrow_in
    );
        if (!borrow_in) begin
            return {1'b0, digit};
        end
        if (digit == '0) begin
            return {1'b1, BCD_NINE};
        end
        return {1'b0, digit - BCD_W'(1)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/microwave_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// microwave_timer_ctrl_if : keypad/run-control inputs and display/status outputs
// Rev 1.0
// ============================================================================
interface microwave_timer_ctrl_if #(
    parameter int NUM_KEYS   = 10,
    parameter int MIN_DIGITS = 2
);

    logic [NUM_KEYS-1:0]     switches;
    logic                    start;
    logic                    stop;
    logic [4*MIN_DIGITS-1:0] minutes;
    logic [3:0]              tens_sec;
    logic [3:0]              units_sec;
    logic                    running;
    logic                    paused;
    logic                    done;
    logic                    beep;

    modport master (
        output switches, start, stop,
        input  minutes, tens_sec, units_sec, running, paused, done, beep
    );

    modport slave (
        input  switches, start, stop,
        output minutes, tens_sec, units_sec, running, paused, done, beep
    );

endinterface
`default_nettype wire

// File: rtl/key_priority_encoder.sv
`default_nettype none
// ============================================================================
// key_priority_encoder : registered highest-index encoder with valid flag
// Rev 1.0
// ============================================================================
module key_priority_encoder #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire  [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0]   code,
    output logic                valid
);

    logic [CODE_W-1:0] w_code;

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                w_code = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code  <= '0;
            valid <= 1'b0;
        end else begin
            code  <= w_code;
            valid <= |keys;
        end
    end

endmodule
`default_nettype wire

// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// microwave_timer_ctrl : keypad time entry, BCD countdown and run control
// Rev 1.0
// ============================================================================
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int NUM_KEYS   = 10,
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 100000000,
    parameter int BEEP_SEC   = 3
) (
    input  wire                    clk,
    input  wire                    rst,
    microwave_timer_ctrl_if.slave  bus
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
    localparam int TIME_W = BCD_W * (MIN_DIGITS + 2);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TIME_W-1:0]   r_time;          // {minutes, tens, units}, BCD
    logic [TIME_W-1:0]   w_time_nxt;
    logic [TIME_W-1:0]   w_time_dec;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [BEEP_W-1:0]   r_beep_cnt;
    logic [BEEP_W-1:0]   w_beep_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_key_valid_d;
    logic [BCD_W-1:0]    w_key_code;
    logic                w_key_valid;
    logic                w_press;
    logic                w_borrow;
    logic                w_tick_tc;
    logic                w_beep_last;
    logic                w_time_zero;
    logic                w_dec_zero;

    key_priority_encoder #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (BCD_W)
    ) u_key_enc (
        .clk   (clk),
        .rst   (rst),
        .keys  (bus.switches),
        .code  (w_key_code),
        .valid (w_key_valid)
    );

    // A press is the rising edge of the registered "any key" flag.
    assign w_press     = w_key_valid & ~r_key_valid_d;
    assign w_tick_tc   = (r_tick == TICK_LAST);
    assign w_beep_last = (r_beep_cnt == BEEP_LAST);
    assign w_time_zero = (r_time == '0);
    assign w_dec_zero  = (w_time_dec == '0);

    // One-second decrement; only consulted while the time is nonzero.
    always_comb begin
        w_time_dec = r_time;
        w_borrow   = 1'b0;
        if (r_time[BCD_W-1:0] != '0) begin
            w_time_dec[BCD_W-1:0] = r_time[BCD_W-1:0] - BCD_W'(1);
        end else if (r_time[2*BCD_W-1:BCD_W] != '0) begin
            w_time_dec[2*BCD_W-1:BCD_W] = r_time[2*BCD_W-1:BCD_W] - BCD_W'(1);
            w_time_dec[BCD_W-1:0]       = BCD_NINE;
        end else begin
            w_time_dec[2*BCD_W-1:0] = {SEC_TENS_WRAP, BCD_NINE};
            w_borrow                = 1'b1;
            for (int d = 0; d < MIN_DIGITS; d++) begin
                {w_borrow, w_time_dec[BCD_W*(d+2) +: BCD_W]} =
                    bcd_dec_digit(r_time[BCD_W*(d+2) +: BCD_W], w_borrow);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_time_nxt     = r_time;
        w_tick_nxt     = r_tick;
        w_beep_cnt_nxt = r_beep_cnt;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tick_nxt     = '0;
                w_beep_cnt_nxt = '0;
                if (bus.stop) begin
                    w_time_nxt = '0;
                end else if (bus.start && !w_time_zero) begin
                    w_state_nxt = ST_RUN;
                end else if (w_press) begin
                    w_time_nxt = {r_time[TIME_W-BCD_W-1:0], w_key_code};
                end
            end

            ST_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_tick_tc) begin
                    w_tick_nxt = '0;
                    w_time_nxt = w_time_dec;
                    if (w_dec_zero) begin
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = ST_DONE;
                        w_beep_cnt_nxt = '0;
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            ST_PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                    w_time_nxt  = '0;
                end else if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_tick_nxt  = '0;
                end
            end

            ST_DONE: begin
                // Any user activity silences the beep; the press is swallowed.
                if (bus.stop || bus.start || w_press) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick_tc) begin
                    w_tick_nxt = '0;
                    if (w_beep_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_beep_cnt_nxt = r_beep_cnt + BEEP_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_time        <= '0;
            r_tick        <= '0;
            r_beep_cnt    <= '0;
            r_done        <= 1'b0;
            r_key_valid_d <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_time        <= w_time_nxt;
            r_tick        <= w_tick_nxt;
            r_beep_cnt    <= w_beep_cnt_nxt;
            r_done        <= w_done_nxt;
            r_key_valid_d <= w_key_valid;
        end
    end

    assign bus.minutes   = r_time[TIME_W-1:2*BCD_W];
    assign bus.tens_sec  = r_time[2*BCD_W-1:BCD_W];
    assign bus.units_sec = r_time[BCD_W-1:0];
    assign bus.running   = (r_state == ST_RUN);
    assign bus.paused    = (r_state == ST_PAUSE);
    assign bus.done      = r_done;
    assign bus.beep      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_microwave_timer_ctrl : directed + randomized bench against a decimal-value model
// Rev 1.0
// ============================================================================
module tb_microwave_timer_ctrl;

    localparam int NUM_KEYS   = 10;
    localparam int MIN_DIGITS = 2;
    localparam int TICK_DIV   = 4;
    localparam int BEEP_SEC   = 2;
    localparam int DIGITS     = MIN_DIGITS + 2;
    localparam int VALUE_MOD  = 10 ** DIGITS;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    microwave_timer_ctrl_if #(.NUM_KEYS(NUM_KEYS), .MIN_DIGITS(MIN_DIGITS)) bus ();

    microwave_timer_ctrl #(
        .NUM_KEYS   (NUM_KEYS),
        .MIN_DIGITS (MIN_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .BEEP_SEC   (BEEP_SEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: the display is a plain decimal number mmss (mins*100 + sec field).
    int                  m_mode;
    int                  m_value;
    int                  m_phase;
    int                  m_beep_cyc;
    bit                  m_done;
    logic [NUM_KEYS-1:0] m_samp1;
    logic [NUM_KEYS-1:0] m_samp2;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int top_key(input logic [NUM_KEYS-1:0] v);
        int k = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) k = i;
        end
        return k;
    endfunction

    function automatic int sec_down(input int v);
        if (v % 100 != 0) return v - 1;
        return v - 100 + 59;
    endfunction

    function automatic logic [4*DIGITS-1:0] exp_disp(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] obs_disp();
        return {bus.minutes, bus.tens_sec, bus.units_sec};
    endfunction

    function automatic logic [3:0] obs_flags();
        return {bus.running, bus.paused, bus.done, bus.beep};
    endfunction

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_value    = 0;
        m_phase    = 0;
        m_beep_cyc = 0;
        m_done     = 1'b0;
        m_samp1    = '0;
        m_samp2    = '0;
    endtask

    task automatic model_step();
        bit press;
        int key;
        press  = (m_samp1 != '0) && (m_samp2 == '0);
        key    = top_key(m_samp1);
        m_done = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (bus.stop) m_value = 0;
                else if (bus.start && m_value != 0) begin
                    m_mode  = M_RUN;
                    m_phase = 0;
                end else if (press) m_value = (m_value * 10 + key) % VALUE_MOD;
            end
            M_RUN: begin
                if (bus.stop) m_mode = M_PAUSE;
                else begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        m_phase = 0;
                        m_value = sec_down(m_value);
                        if (m_value == 0) begin
                            m_done     = 1'b1;
                            m_mode     = M_DONE;
                            m_beep_cyc = 0;
                        end
                    end
                end
            end
            M_PAUSE: begin
                if (bus.stop) begin
                    m_mode  = M_IDLE;
                    m_value = 0;
                end else if (bus.start) begin
                    m_mode  = M_RUN;
                    m_phase = 0;
                end
            end
            default: begin
                if (bus.stop || bus.start || press) m_mode = M_IDLE;
                else begin
                    m_beep_cyc++;
                    if (m_beep_cyc == BEEP_SEC * TICK_DIV) m_mode = M_IDLE;
                end
            end
        endcase
        m_samp2 = m_samp1;
        m_samp1 = bus.switches;
    endtask

    task automatic check_model();
        logic [3:0] ef;
        ef = {m_mode == M_RUN, m_mode == M_PAUSE, m_done, m_mode == M_DONE};
        check_value("display", 32'(obs_disp()), 32'(exp_disp(m_value)));
        check_value("flags", 32'(obs_flags()), 32'(ef));
    endtask

    // Inputs change only after the falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic press_key(input int k);
        bus.switches = NUM_KEYS'(1) << k;
        repeat (2) cycle();
        bus.switches = '0;
        repeat (2) cycle();
    endtask

    task automatic clear_time();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        cycle();
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        bus.switches = NUM_KEYS'(1) << 3;
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        model_reset();

        // Reset held with key and start active
        repeat (3) cycle();
        check_value("rst_disp", 32'(obs_disp()), 32'h0);
        check_value("rst_flags", 32'(obs_flags()), 32'h0);
        bus.switches = '0;
        bus.start    = 1'b0;
        rst          = 1'b1;
        repeat (2) cycle();

        // Entry: 1,2,3,4,5 -> 23:45; held key 7 shifts once
        for (int k = 1; k <= 5; k++) press_key(k);
        check_value("entry_2345", 32'(obs_disp()), 32'h2345);
        bus.switches = NUM_KEYS'(1) << 7;
        repeat (10) cycle();
        bus.switches = '0;
        repeat (2) cycle();
        check_value("hold_key7", 32'(obs_disp()), 32'h3457);

        // Countdown from 1:00
        clear_time();
        press_key(1); press_key(0); press_key(0);
        check_value("entry_100", 32'(obs_disp()), 32'h0100);
        start_pulse();
        repeat (3) cycle();
        check_value("pre_first_dec", 32'(obs_disp()), 32'h0100);
        cycle();
        check_value("first_dec_059", 32'(obs_disp()), 32'h0059);
        repeat (4) cycle();
        check_value("second_dec_058", 32'(obs_disp()), 32'h0058);
        bus.stop = 1'b1;
        repeat (2) cycle();
        bus.stop = 1'b0;
        check_value("cancel_disp", 32'(obs_disp()), 32'h0);

        // 0:90 runs exactly 90 seconds
        press_key(9); press_key(0);
        check_value("entry_090", 32'(obs_disp()), 32'h0090);
        start_pulse();
        repeat (359) cycle();
        check_value("last_second", 32'(obs_disp()), 32'h0001);
        cycle();
        check_value("t90_done", 32'(obs_flags()), 32'b0011);
        repeat (8) cycle();
        check_value("t90_idle", 32'(obs_flags()), 32'b0000);

        // Done pulse and beep duration
        press_key(2);
        start_pulse();
        repeat (7) cycle();
        check_value("before_done", 32'(obs_flags()), 32'b1000);
        cycle();
        check_value("done_pulse", 32'(obs_flags()), 32'b0011);
        repeat (7) cycle();
        check_value("beep_last", 32'(obs_flags()), 32'b0001);
        cycle();
        check_value("beep_over", 32'(obs_flags()), 32'b0000);

        // Pause, resume, cancel
        press_key(1); press_key(0);
        start_pulse();
        repeat (5) cycle();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        check_value("paused_flag", 32'(obs_flags()), 32'b0100);
        repeat (6) cycle();
        check_value("paused_hold", 32'(obs_disp()), 32'h0009);
        start_pulse();
        repeat (3) cycle();
        check_value("resume_hold", 32'(obs_disp()), 32'h0009);
        cycle();
        check_value("resume_dec", 32'(obs_disp()), 32'h0008);
        bus.stop = 1'b1;
        repeat (2) cycle();
        bus.stop = 1'b0;
        check_value("stop_stop", 32'({obs_disp(), obs_flags()}), 32'h0);

        // Priority and corners
        press_key(4);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cycle();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_value("start_stop_idle", 32'({obs_disp(), obs_flags()}), 32'h0);
        start_pulse();
        cycle();
        check_value("start_at_zero", 32'(obs_flags()), 32'b0000);
        press_key(3);
        start_pulse();
        press_key(7);
        check_value("keys_in_run", 32'(obs_disp()), 32'h0002);
        repeat (2) cycle();
        check_value("run_before_rst", 32'(obs_flags()), 32'b1000);
        rst = 1'b0;
        model_reset();
        #2;
        check_value("async_rst", 32'({obs_disp(), obs_flags()}), 32'h0);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // Randomized short cooks with interruptions
        for (int t = 0; t < 10; t++) begin
            clear_time();
            repeat ($urandom_range(1, 2)) press_key($urandom_range(0, NUM_KEYS - 1));
            start_pulse();
            for (int c = 0; c < 80; c++) begin
                bus.stop     = ($urandom_range(0, 39) == 0);
                bus.start    = ($urandom_range(0, 9) == 0);
                bus.switches = ($urandom_range(0, 19) == 0) ?
                               NUM_KEYS'(1) << $urandom_range(0, NUM_KEYS - 1) : '0;
                cycle();
            end
            bus.stop     = 1'b0;
            bus.start    = 1'b0;
            bus.switches = '0;
        end

        // Free-running random inputs with held switch patterns
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) bus.switches = '0;
                else if (r < 9) bus.switches = NUM_KEYS'(1) << $urandom_range(0, NUM_KEYS - 1);
                else bus.switches = NUM_KEYS'($urandom_range(0, (1 << NUM_KEYS) - 1));
            end
            bus.start = ($urandom_range(0, 29) == 0);
            bus.stop  = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
